pulse_stretch: RTL and testbench

//  Converts single-cycle strobes (e.g. from our edge-to-pulse block) back into

---
 rtl/pulse_stretch.sv | 185 ++++++++++++++++++
 tb/tb_pulse_stretch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches single-cycle strobes into WIDTH-cycle level pulses and queues
// strobes that arrive while busy. Define PULSE_STRETCH_RETRIG_EN for retriggerable mode.
module pulse_stretch #(
   parameter  int WIDTH = 8,
   parameter  int GAP   = 2,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pulse,
   input  logic             i_clr_ovf,
   output logic             o_level,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pending,
   output logic             o_overflow
);
   localparam int TMR_MAX = (WIDTH > GAP) ? WIDTH : GAP;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] WIDTH_LOAD = TMR_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [TMR_W-1:0] tmr_r;
   logic [TMR_W-1:0] tmr_s;
   logic [CNT_W-1:0] pend_r;
   logic [CNT_W-1:0] pend_s;
   logic             ovf_r;
   logic             ovf_s;
   logic             level_r;
   logic             busy_r;
   logic             tmr_done_s;

   assign tmr_done_s = (tmr_r == {TMR_W{1'b0}});

`ifdef PULSE_STRETCH_RETRIG_EN
   logic unused_clr_s;
   assign unused_clr_s = i_clr_ovf;

   // Retriggerable sequencing: any strobe while high restarts the width count
   always_comb begin
      state_s = state_r;
      tmr_s   = tmr_r;
      pend_s  = {CNT_W{1'b0}};
      ovf_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (i_pulse) begin
               state_s = ST_HIGH;
               tmr_s   = WIDTH_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (i_pulse) begin
               tmr_s = WIDTH_LOAD;
            end else if (tmr_done_s) begin
               state_s = ST_IDLE;
            end else begin
               tmr_s = tmr_r - TMR_W'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            tmr_s   = {TMR_W{1'b0}};
         end
      endcase
   end
`else
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP - 1);
   localparam logic [CNT_W-1:0] PEND_FULL = CNT_W'(DEPTH);

   logic pend_nz_s;
   logic start_s;
   logic enq_s;
   logic deq_s;
   logic drop_s;

   assign pend_nz_s = (pend_r != {CNT_W{1'b0}});

   // Queued sequencing: decides pulse starts and whether a strobe enqueues or dequeues
   always_comb begin
      state_s = state_r;
      tmr_s   = tmr_r;
      start_s = 1'b0;
      enq_s   = 1'b0;
      deq_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_s = i_pulse | pend_nz_s;
            deq_s   = pend_nz_s;
            enq_s   = i_pulse & pend_nz_s;
         end
         ST_HIGH: begin
            enq_s = i_pulse;
            if (tmr_done_s) begin
               state_s = ST_GAP;
               tmr_s   = GAP_LOAD;
            end else begin
               tmr_s = tmr_r - TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (tmr_done_s) begin
               // a strobe in the last gap cycle launches the next pulse itself
               state_s = ST_IDLE;
               start_s = i_pulse | pend_nz_s;
               deq_s   = pend_nz_s;
               enq_s   = i_pulse & pend_nz_s;
            end else begin
               tmr_s = tmr_r - TMR_W'(1);
               enq_s = i_pulse;
            end
         end
         default: begin
            state_s = ST_IDLE;
            tmr_s   = {TMR_W{1'b0}};
         end
      endcase
      if (start_s) begin
         state_s = ST_HIGH;
         tmr_s   = WIDTH_LOAD;
      end else begin
         state_s = state_s;
      end
   end

   // Pending count and sticky overflow; a new drop beats a same-cycle clear
   always_comb begin
      pend_s = pend_r;
      ovf_s  = ovf_r;
      drop_s = 1'b0;
      if (enq_s && !deq_s) begin
         if (pend_r == PEND_FULL) begin
            drop_s = 1'b1;
         end else begin
            pend_s = pend_r + CNT_W'(1);
         end
      end else if (deq_s && !enq_s) begin
         pend_s = pend_r - CNT_W'(1);
      end else begin
         pend_s = pend_r;
      end
      if (drop_s) begin
         ovf_s = 1'b1;
      end else if (i_clr_ovf) begin
         ovf_s = 1'b0;
      end else begin
         ovf_s = ovf_r;
      end
   end
`endif

   // State, counters and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         tmr_r   <= {TMR_W{1'b0}};
         pend_r  <= {CNT_W{1'b0}};
         ovf_r   <= 1'b0;
         level_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         tmr_r   <= tmr_s;
         pend_r  <= pend_s;
         ovf_r   <= ovf_s;
         level_r <= (state_s == ST_HIGH);
         busy_r  <= (state_s != ST_IDLE) || (pend_s != {CNT_W{1'b0}});
      end
   end

   assign o_level    = level_r;
   assign o_busy     = busy_r;
   assign o_pending  = pend_r;
   assign o_overflow = ovf_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: vector table plus hand-written corner sequences; expected pulse
// start cycles come from a timeline model and are scoreboarded against o_level rises.
`timescale 1ns/1ps
module tb_pulse_stretch;
   localparam int WIDTH = 8;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             i_clk;
   logic             i_rst_n;
   logic             i_pulse;
   logic             i_clr_ovf;
   logic             o_level;
   logic             o_busy;
   logic [CNT_W-1:0] o_pending;
   logic             o_overflow;

   pulse_stretch #(.WIDTH(WIDTH), .GAP(GAP), .DEPTH(DEPTH)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_pulse   (i_pulse),
      .i_clr_ovf (i_clr_ovf),
      .o_level   (o_level),
      .o_busy    (o_busy),
      .o_pending (o_pending),
      .o_overflow(o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      int s;
      int st;
   } ent_t;

   typedef struct {
      logic [31:0] mask;
      int          clr_cyc;
      int          exp_pulses;
      int          exp_peak;
      logic        exp_ovf;
   } vec_t;

   ent_t ents[$];
   int   exp_q[$];
   vec_t vecs[9];
   int   n_pass = 0;
   int   n_chk  = 0;
   int   cyc    = 0;
   int   s_cyc  = 0;
   int   last_st;
   int   rises;
   int   peak;
   int   pend_v;
   logic exp_ovf;
   logic prev_lvl;
   logic lvl_v;
   logic busy_v;
   logic ovf_v;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, s_cyc, act, exp);
   endtask

   function automatic int m_pending(int c);
      int n = 0;
      foreach (ents[i]) if (ents[i].s < c && ents[i].st > c) n++;
      return n;
   endfunction

   function automatic int m_active(int c, int len);
      int r = 0;
      foreach (ents[i]) if (ents[i].st <= c && c < ents[i].st + len) r = 1;
      return r;
   endfunction

   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_pulse   = 1'b0;
      i_clr_ovf = 1'b0;
      ents.delete();
      exp_q.delete();
      last_st  = -1000;
      exp_ovf  = 1'b0;
      prev_lvl = 1'b0;
      rises    = 0;
      peak     = 0;
      @(negedge i_clk);
      chk("reset_level", o_level, 0);
      chk("reset_busy", o_busy, 0);
      chk("reset_pending", o_pending, 0);
      chk("reset_overflow", o_overflow, 0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic step(input logic p, input logic clr);
      i_pulse   = p;
      i_clr_ovf = clr;
      @(negedge i_clk);
      s_cyc  = cyc;
      lvl_v  = o_level;
      busy_v = o_busy;
      pend_v = o_pending;
      ovf_v  = o_overflow;
   endtask

   task automatic adv();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   // one cycle against the timeline model: strobe accepted -> start pushed to scoreboard
   task automatic run_cycle(input logic p, input logic clr);
      int   waiting;
      int   st;
      int   e;
      logic drop;
      ent_t ent;
      drop = 1'b0;
      if (p) begin
         waiting = 0;
         foreach (ents[i]) if (ents[i].s < cyc && ents[i].st > cyc + 1) waiting++;
         if (waiting >= DEPTH) begin
            drop = 1'b1;
         end else begin
            st = (cyc + 1 > last_st + WIDTH + GAP) ? cyc + 1 : last_st + WIDTH + GAP;
            ent.s  = cyc;
            ent.st = st;
            ents.push_back(ent);
            exp_q.push_back(st);
            last_st = st;
         end
      end
      step(p, clr);
      chk("level", lvl_v, m_active(cyc, WIDTH));
      chk("busy", busy_v, (m_active(cyc, WIDTH + GAP) != 0 || m_pending(cyc) != 0) ? 1 : 0);
      chk("pending", pend_v, m_pending(cyc));
      chk("overflow", ovf_v, exp_ovf);
      if (lvl_v && !prev_lvl) begin
         e = -1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         chk("rise_cycle", cyc, e);
         rises++;
      end
      prev_lvl = lvl_v;
      if (pend_v > peak) peak = pend_v;
      if (drop) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
      adv();
   endtask

   initial begin
      i_rst_n   = 1'b0;
      i_pulse   = 1'b0;
      i_clr_ovf = 1'b0;
`ifndef PULSE_STRETCH_RETRIG_EN
      vecs[0] = '{32'h0000_0400, -1, 1, 0, 1'b0};
      vecs[1] = '{32'h0000_5400, -1, 3, 2, 1'b0};
      vecs[2] = '{32'h0001_FC00, -1, 5, 4, 1'b1};
      vecs[3] = '{32'h0001_FC00, 25, 5, 4, 1'b0};
      vecs[4] = '{32'h0001_FC00, 16, 5, 4, 1'b1};
      vecs[5] = '{32'h0010_0400, -1, 2, 0, 1'b0};
      vecs[6] = '{32'h0010_1400, -1, 3, 1, 1'b0};
      vecs[7] = '{32'h0008_0400, -1, 2, 1, 1'b0};
      vecs[8] = '{32'h0004_0400, -1, 2, 1, 1'b0};

      for (int v = 0; v < 9; v++) begin
         do_reset();
         for (int c = 0; c < 80; c++)
            run_cycle((c < 32) ? vecs[v].mask[c] : 1'b0, (c == vecs[v].clr_cyc) ? 1'b1 : 1'b0);
         chk($sformatf("vec%0d_pulses", v), rises, vecs[v].exp_pulses);
         chk($sformatf("vec%0d_peak", v), peak, vecs[v].exp_peak);
         chk($sformatf("vec%0d_ovf", v), ovf_v, vecs[v].exp_ovf);
         chk($sformatf("vec%0d_sb_left", v), exp_q.size(), 0);
      end

      // single strobe: exact edges of level and busy
      do_reset();
      for (int c = 0; c < 26; c++) begin
         run_cycle((c == 10) ? 1'b1 : 1'b0, 1'b0);
         if (c == 10) chk("t1_level_10", lvl_v, 0);
         if (c == 11) chk("t1_level_11", lvl_v, 1);
         if (c == 18) chk("t1_level_18", lvl_v, 1);
         if (c == 19) chk("t1_level_19", lvl_v, 0);
         if (c == 20) chk("t1_busy_20", busy_v, 1);
         if (c == 21) chk("t1_busy_21", busy_v, 0);
      end

      // overflow set by drop, cleared one cycle after i_clr_ovf
      do_reset();
      for (int c = 0; c < 36; c++) begin
         run_cycle((c >= 10 && c <= 16) ? 1'b1 : 1'b0, (c == 30) ? 1'b1 : 1'b0);
         if (c == 15) chk("t3_ovf_15", ovf_v, 0);
         if (c == 16) chk("t3_ovf_16", ovf_v, 1);
         if (c == 30) chk("t3_ovf_30", ovf_v, 1);
         if (c == 31) chk("t3_ovf_31", ovf_v, 0);
      end

      // asynchronous reset mid-pulse discards the queue
      do_reset();
      for (int c = 0; c < 14; c++) begin
         run_cycle((c >= 10 && c <= 12) ? 1'b1 : 1'b0, 1'b0);
         if (c == 13) chk("t4_pending_13", pend_v, 2);
      end
      s_cyc = cyc;
      chk("t4_level_before_rst", o_level, 1);
      i_rst_n = 1'b0;
      #1;
      chk("t4_async_level", o_level, 0);
      chk("t4_async_busy", o_busy, 0);
      chk("t4_async_pending", o_pending, 0);
      chk("t4_async_overflow", o_overflow, 0);
      do_reset();
      for (int c = 0; c < 40; c++) run_cycle(1'b0, 1'b0);
      chk("t4_no_resume", rises, 0);
`else
      do_reset();
      for (int c = 0; c < 45; c++) begin
         step((c == 10 || c == 15 || c == 30) ? 1'b1 : 1'b0, (c == 20) ? 1'b1 : 1'b0);
         chk("rt_level", lvl_v, ((c >= 11 && c <= 23) || (c >= 31 && c <= 38)) ? 1 : 0);
         chk("rt_busy", busy_v, ((c >= 11 && c <= 23) || (c >= 31 && c <= 38)) ? 1 : 0);
         chk("rt_pending", pend_v, 0);
         chk("rt_overflow", ovf_v, 0);
         adv();
      end
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
